// File: rtl/imem_loader.sv
// Boot loader: assembles little-endian words from a byte stream, writes them into
// instruction memory, then releases cpu_reset. Define IMEM_LOADER_CHECKSUM_EN for a trailing checksum word.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   word_count
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_LEN, S_DATA, S_CKSUM, S_DRAIN, S_RUN, S_ERR} state_t;
`else
    typedef enum logic [2:0] {S_LEN, S_DATA, S_DRAIN, S_RUN, S_ERR} state_t;
`endif

    localparam logic [32:0] DEPTH = 33'd1 << ADDR_W;

    state_t            state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [23:0]       asm_q, asm_d;
    logic [31:0]       len_q, len_d;
    logic [ADDR_W:0]   wc_q, wc_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       word;
    logic              accept;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]       sum_q, sum_d;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_LEN;
            byte_cnt_q <= 2'd0;
            asm_q      <= 24'd0;
            len_q      <= 32'd0;
            wc_q       <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q      <= 32'd0;
`endif
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            len_q      <= len_d;
            wc_q       <= wc_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    // The fourth byte is never stored; it is merged straight into the completed word.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        len_d      = len_q;
        wc_d       = wc_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d      = sum_q;
`endif
        word   = {rx_data, asm_q};
        accept = rx_valid && rx_ready;

        if (accept) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            case (byte_cnt_q)
                2'd0:    asm_d[7:0]   = rx_data;
                2'd1:    asm_d[15:8]  = rx_data;
                2'd2:    asm_d[23:16] = rx_data;
                default: ;
            endcase
            if (byte_cnt_q == 2'd3) begin
                case (state_q)
                    S_LEN: begin
                        len_d = word;
                        if (word == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state_d = S_CKSUM;
`else
                            state_d = S_RUN;
`endif
                        end else if ({1'b0, word} > DEPTH) begin
                            state_d = S_ERR;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                    S_DATA: begin
                        we_d    = 1'b1;
                        waddr_d = wc_q[ADDR_W-1:0];
                        wdata_d = word;
                        wc_d    = wc_q + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum_d   = sum_q + word;
                        if (32'(wc_d) == len_q) state_d = S_CKSUM;
`else
                        if (32'(wc_d) == len_q) state_d = S_DRAIN;
`endif
                    end
`ifdef IMEM_LOADER_CHECKSUM_EN
                    S_CKSUM: begin
                        if (word != sum_q)        state_d = S_ERR;
                        else if (len_q == 32'd0)  state_d = S_RUN;
                        else                      state_d = S_DRAIN;
                    end
`endif
                    default: ;
                endcase
            end
        end

        if (state_q == S_DRAIN) state_d = S_RUN;
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    assign rx_ready = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CKSUM);
`else
    assign rx_ready = (state_q == S_LEN) || (state_q == S_DATA);
`endif
    assign imem_we    = we_q;
    assign imem_waddr = waddr_q;
    assign imem_wdata = wdata_q;
    assign cpu_reset  = (state_q != S_RUN);
    assign load_done  = (state_q == S_RUN);
    assign load_err   = (state_q == S_ERR);
    assign word_count = wc_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: byte-count based reference model compared every
// cycle, plus literal expectations for each directed scenario.
module tb_imem_loader;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;
    logic              cpu_reset;
    logic              load_done;
    logic              load_err;
    logic [ADDR_W:0]   word_count;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .imem_we(imem_we), .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .load_done(load_done),
        .load_err(load_err), .word_count(word_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks the byte stream by position (4 bytes length, 4 per word, then checksum)
    int          m_n = 0;
    logic [31:0] m_cur = 0;
    logic [31:0] m_len = 0;
    logic [31:0] m_sum = 0;
    int          m_wc = 0;
    bit          m_we = 0, m_drain = 0, m_done = 0, m_err = 0;
    logic [31:0] m_addr = 0, m_data = 0;
    int          k;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_n = 0; m_cur = 0; m_len = 0; m_sum = 0; m_wc = 0;
            m_we = 0; m_drain = 0; m_done = 0; m_err = 0; m_addr = 0; m_data = 0;
        end else begin
            m_we = 0;
            if (m_drain) begin
                m_drain = 0;
                m_done  = 1;
            end else if (!(m_done || m_err) && rx_valid) begin
                m_n++;
                m_cur = (m_cur >> 8) | {rx_data, 24'h0};
                if (m_n % 4 == 0) begin
                    k = m_n / 4;
                    if (k == 1) begin
                        m_len = m_cur;
                        if (m_len > 32'(DEPTH)) m_err = 1;
`ifndef IMEM_LOADER_CHECKSUM_EN
                        else if (m_len == 0) m_done = 1;
`endif
                    end else if ((k - 1) <= int'(m_len)) begin
                        m_we   = 1;
                        m_addr = 32'(k - 2);
                        m_data = m_cur;
                        m_wc++;
                        m_sum  = m_sum + m_cur;
`ifndef IMEM_LOADER_CHECKSUM_EN
                        if (m_wc == int'(m_len)) m_drain = 1;
`endif
                    end else begin
                        if (m_cur != m_sum)  m_err = 1;
                        else if (m_len == 0) m_done = 1;
                        else                 m_drain = 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check_output("rx_ready",   32'(rx_ready),   32'(!(m_done || m_err || m_drain)));
            check_output("imem_we",    32'(imem_we),    32'(m_we));
            check_output("cpu_reset",  32'(cpu_reset),  32'(!m_done));
            check_output("load_done",  32'(load_done),  32'(m_done));
            check_output("load_err",   32'(load_err),   32'(m_err));
            check_output("word_count", 32'(word_count), 32'(m_wc));
            if (m_we) begin
                check_output("imem_waddr", 32'(imem_waddr), m_addr);
                check_output("imem_wdata", imem_wdata, m_data);
            end
        end
    end

    // Observed writes, for the literal per-scenario checks
    int          pulses = 0;
    logic [31:0] mem_seen [DEPTH];

    always @(negedge clk) begin
        if (!reset && imem_we) begin
            pulses++;
            mem_seen[imem_waddr] = imem_wdata;
        end
    end

    logic [7:0] prog3 [16] = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                               8'h13, 8'h01, 8'hA0, 8'h00, 8'hB3, 8'h81, 8'h20, 8'h00};

    task automatic clear_obs();
        pulses = 0;
        for (int i = 0; i < DEPTH; i++) mem_seen[i] = 32'h0;
    endtask

    task automatic do_reset();
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        clear_obs();
    endtask

    task automatic apply_stimulus(input logic [7:0] b, input int idle);
        repeat (idle) @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int max_idle);
        for (int i = 0; i < 4; i++) apply_stimulus(w[8*i +: 8], $urandom_range(0, max_idle));
    endtask

    task automatic send_prog3(input int max_idle);
        for (int i = 0; i < 16; i++) apply_stimulus(prog3[i], $urandom_range(0, max_idle));
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(32'h01108359, max_idle);
`endif
    endtask

    task automatic verify_prog3();
`ifndef IMEM_LOADER_CHECKSUM_EN
        check_output("last_pulse_we", 32'(imem_we), 32'd1);
`endif
        check_output("drain_cpu_reset", 32'(cpu_reset), 32'd1);
        @(negedge clk);
        check_output("run_cpu_reset", 32'(cpu_reset), 32'd0);
        check_output("run_load_done", 32'(load_done), 32'd1);
        check_output("run_word_count", 32'(word_count), 32'd3);
        check_output("pulse_count", 32'(pulses), 32'd3);
        check_output("mem0", mem_seen[0], 32'h00500093);
        check_output("mem1", mem_seen[1], 32'h00A00113);
        check_output("mem2", mem_seen[2], 32'h002081B3);
    endtask

    initial begin
        #12;
        check_output("rst_rx_ready", 32'(rx_ready), 32'd1);
        check_output("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check_output("rst_load_done", 32'(load_done), 32'd0);
        check_output("rst_word_count", 32'(word_count), 32'd0);
        check_output("rst_imem_we", 32'(imem_we), 32'd0);
        @(negedge clk) reset = 1'b0;
        clear_obs();

        $display("[TB] length-3 load");
        send_prog3(0);
        verify_prog3();

        $display("[TB] empty program");
        do_reset();
        send_word(32'h0, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(32'h0, 0);
`endif
        check_output("empty_cpu_reset", 32'(cpu_reset), 32'd0);
        check_output("empty_load_done", 32'(load_done), 32'd1);
        repeat (2) @(negedge clk);
        check_output("empty_pulses", 32'(pulses), 32'd0);

        $display("[TB] oversize length");
        do_reset();
        send_word(32'h00000101, 0);
        check_output("over_load_err", 32'(load_err), 32'd1);
        check_output("over_rx_ready", 32'(rx_ready), 32'd0);
        check_output("over_cpu_reset", 32'(cpu_reset), 32'd1);
        send_word(32'h03020100, 1);
        check_output("over_pulses", 32'(pulses), 32'd0);
        check_output("over_word_count", 32'(word_count), 32'd0);
        check_output("over_err_held", 32'(load_err), 32'd1);

        $display("[TB] bursty source");
        do_reset();
        send_prog3(5);
        verify_prog3();
        send_word(32'h11223344, 2);
        send_word(32'h55667788, 0);
        check_output("run_pulses", 32'(pulses), 32'd3);
        check_output("run_done_held", 32'(load_done), 32'd1);

        $display("[TB] mid-load reset");
        do_reset();
        for (int i = 0; i < 12; i++) apply_stimulus(prog3[i], 0);
        #3 reset = 1'b1;
        #1;
        check_output("mid_rx_ready", 32'(rx_ready), 32'd1);
        check_output("mid_imem_we", 32'(imem_we), 32'd0);
        check_output("mid_waddr", 32'(imem_waddr), 32'd0);
        check_output("mid_wdata", imem_wdata, 32'd0);
        check_output("mid_cpu_reset", 32'(cpu_reset), 32'd1);
        check_output("mid_load_done", 32'(load_done), 32'd0);
        check_output("mid_load_err", 32'(load_err), 32'd0);
        check_output("mid_word_count", 32'(word_count), 32'd0);
        @(negedge clk) reset = 1'b0;
        clear_obs();
        send_word(32'h00000001, 0);
        send_word(32'hDEADBEEF, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(32'hDEADBEEF, 0);
`endif
        @(negedge clk);
        check_output("reload_pulses", 32'(pulses), 32'd1);
        check_output("reload_mem0", mem_seen[0], 32'hDEADBEEF);
        check_output("reload_done", 32'(load_done), 32'd1);
        check_output("reload_cpu_reset", 32'(cpu_reset), 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        $display("[TB] bad checksum");
        do_reset();
        for (int i = 0; i < 16; i++) apply_stimulus(prog3[i], 0);
        send_word(32'h0110835A, 0);
        @(negedge clk);
        check_output("ck_load_err", 32'(load_err), 32'd1);
        check_output("ck_cpu_reset", 32'(cpu_reset), 32'd1);
        check_output("ck_rx_ready", 32'(rx_ready), 32'd0);
        check_output("ck_pulses", 32'(pulses), 32'd3);
`endif

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
